// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, controller state encoding and scoreboard sizing for the decode hazard controller.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b0111;
  localparam logic [3:0] OP_BR   = 4'b0010;
  localparam logic [3:0] OP_JMP  = 4'b0100;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FLUSH  = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_HALTED = 2'b11
  } ctrl_state_t;

  // Counter must hold WB_LAT itself, so size for WB_LAT+1 values.
  function automatic int sb_cnt_w(input int wb_lat);
    return (wb_lat < 1) ? 1 : $clog2(wb_lat + 1);
  endfunction

  localparam int WB_LAT_DEFAULT = 3;
  localparam int SB_CNT_W       = sb_cnt_w(WB_LAT_DEFAULT);

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register write-back countdown with load tags; answers "is this source pending" for decode.
// PIPE_HAZARD_FORWARD_EN narrows pending to load-use at distance one.
module reg_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  parameter  int WB_LAT   = 3,
  localparam int RW       = $clog2(NUM_REGS),
  localparam int CW       = sb_cnt_w(WB_LAT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_vld,
  input  logic [RW-1:0]       set_reg,
  input  logic                set_load,
  input  logic [RW-1:0]       src1,
  input  logic [RW-1:0]       src2,
  output logic                pend1,
  output logic                pend2,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [CW-1:0]       cnt_q [NUM_REGS];
  logic [CW-1:0]       cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] load_q;
  logic [NUM_REGS-1:0] load_d;

  always_comb begin
    load_d = load_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r]     = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : cnt_q[r];
      busy_mask[r] = (cnt_q[r] != '0);
    end
    // A new issue overrides the ordinary decrement of the same entry.
    if (set_vld) begin
      cnt_d[set_reg]  = CW'(WB_LAT);
      load_d[set_reg] = set_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      load_q <= load_d;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef PIPE_HAZARD_FORWARD_EN
  assign pend1 = load_q[src1] & (cnt_q[src1] == CW'(WB_LAT));
  assign pend2 = load_q[src2] & (cnt_q[src2] == CW'(WB_LAT));
`else
  assign pend1 = busy_mask[src1];
  assign pend2 = busy_mask[src2];
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage sequencer: RAW stalls, branch flushes and halt drain for the 16-bit pipeline.
// Optional macro PIPE_HAZARD_FORWARD_EN selects the forwarding-aware hazard rule in the scoreboard.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter  int NUM_REGS  = 8,
  parameter  int WB_LAT    = 3,
  parameter  int FLUSH_CYC = 1,
  localparam int RW        = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [3:0]          id_op,
  input  logic [RW-1:0]       id_src1,
  input  logic                id_src1_en,
  input  logic [RW-1:0]       id_src2,
  input  logic                id_src2_en,
  input  logic [RW-1:0]       id_wr_reg,
  input  logic                id_wr_en,
  input  logic                ex_br_valid,
  input  logic                ex_br_taken,
  output logic                stall_if,
  output logic                bubble_id,
  output logic                flush_if,
  output logic                halted,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  ctrl_state_t    state_q;
  logic [FCW-1:0] flush_cnt_q;
  logic           halted_q;
  logic           pend1, pend2;
  logic           hazard, flush_now, issue, in_run, hold;

  assign in_run    = (state_q == ST_RUN);
  assign hold      = (state_q == ST_DRAIN) | (state_q == ST_HALTED);
  assign hazard    = id_valid & ((id_src1_en & pend1) | (id_src2_en & pend2));
  assign flush_now = !rst & ex_br_valid & ex_br_taken & (in_run | (state_q == ST_FLUSH));
  assign issue     = !rst & id_valid & in_run & !hazard & !flush_now;

  // Outputs are forced low while reset is asserted, regardless of inputs.
  assign flush_if  = !rst & (flush_now | (state_q == ST_FLUSH));
  assign stall_if  = !rst & ((in_run & hazard & !flush_now) | hold);
  assign bubble_id = stall_if | flush_if;
  assign halted    = halted_q;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .WB_LAT   (WB_LAT)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_vld   (issue & id_wr_en),
    .set_reg   (id_wr_reg),
    .set_load  (id_op == OP_LD),
    .src1      (id_src1),
    .src2      (id_src2),
    .pend1     (pend1),
    .pend2     (pend2),
    .busy_mask (busy_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush_now) begin
            if (FLUSH_CYC > 1) begin
              state_q     <= ST_FLUSH;
              flush_cnt_q <= FCW'(FLUSH_CYC - 1);
            end
          end else if (issue && id_op == OP_HALT) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_FLUSH: begin
          if (flush_now) begin
            flush_cnt_q <= FCW'(FLUSH_CYC - 1);
          end else if (flush_cnt_q <= FCW'(1)) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FCW'(1);
          end
        end
        ST_DRAIN: begin
          if (busy_mask == '0) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with FLUSH_CYC=2 covers multi-cycle flush.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [3:0] OP_ALU = 4'b0001;

  logic       clk, rst;
  logic       id_valid, id_src1_en, id_src2_en, id_wr_en, ex_br_valid, ex_br_taken;
  logic [3:0] id_op;
  logic [2:0] id_src1, id_src2, id_wr_reg;
  logic       stall_if, bubble_id, flush_if, halted;
  logic       stall_if2, bubble_id2, flush_if2, halted2;
  logic [7:0] busy_mask, busy_mask2;
  logic [3:0] ctl1, ctl2;

  int checks = 0;
  int errors = 0;

  assign ctl1 = {stall_if, bubble_id, flush_if, halted};
  assign ctl2 = {stall_if2, bubble_id2, flush_if2, halted2};

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_src1(id_src1), .id_src1_en(id_src1_en), .id_src2(id_src2), .id_src2_en(id_src2_en),
    .id_wr_reg(id_wr_reg), .id_wr_en(id_wr_en), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
    .stall_if(stall_if), .bubble_id(bubble_id), .flush_if(flush_if), .halted(halted),
    .busy_mask(busy_mask)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYC(2)) u_dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_src1(id_src1), .id_src1_en(id_src1_en), .id_src2(id_src2), .id_src2_en(id_src2_en),
    .id_wr_reg(id_wr_reg), .id_wr_en(id_wr_en), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
    .stall_if(stall_if2), .bubble_id(bubble_id2), .flush_if(flush_if2), .halted(halted2),
    .busy_mask(busy_mask2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic [3:0] op, input logic [2:0] s1, input logic e1,
                        input logic [2:0] s2, input logic e2, input logic [2:0] wr, input logic we);
    id_valid = v; id_op = op; id_src1 = s1; id_src1_en = e1;
    id_src2 = s2; id_src2_en = e2; id_wr_reg = wr; id_wr_en = we;
  endtask

  task automatic br(input logic v, input logic t);
    ex_br_valid = v; ex_br_taken = t;
  endtask

  task automatic idle();
    id_set(1'b0, OP_ALU, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    br(1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    // ctl vectors are {stall_if, bubble_id, flush_if, halted}
    rst = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      id_set(1'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
             3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
      br(1'b1, 1'b1);
      settle();
      chk("rst_ctl", {4'h0, ctl1}, 8'h00);
      chk("rst_busy", busy_mask, 8'h00);
      chk("rst_ctl2", {4'h0, ctl2}, 8'h00);
      tick();
    end
    idle();
    rst = 1'b0;

    // Independent ops issue back to back
    id_set(1'b1, OP_ALU, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1);
    settle(); chk("ind0_ctl", {4'h0, ctl1}, 8'h00); chk("ind0_busy", busy_mask, 8'h00);
    tick();
    id_set(1'b1, OP_ALU, 3'd4, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1);
    settle(); chk("ind1_ctl", {4'h0, ctl1}, 8'h00); chk("ind1_busy", busy_mask, 8'h02);
    tick();
    id_set(1'b1, OP_ALU, 3'd5, 1'b1, 3'd6, 1'b1, 3'd3, 1'b1);
    settle(); chk("ind2_ctl", {4'h0, ctl1}, 8'h00); chk("ind2_busy", busy_mask, 8'h06);
    tick();
    idle();
    settle(); chk("ind3_busy", busy_mask, 8'h0E);
    tick(); settle(); chk("ind4_busy", busy_mask, 8'h0C);
    tick(); settle(); chk("ind5_busy", busy_mask, 8'h08);
    tick(); settle(); chk("ind6_busy", busy_mask, 8'h00);
    tick();

`ifndef PIPE_HAZARD_FORWARD_EN
    // RAW without forwarding: three stall cycles, issue on the fourth
    id_set(1'b1, OP_ALU, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
    settle(); chk("raw_w_ctl", {4'h0, ctl1}, 8'h00);
    tick();
    id_set(1'b1, OP_ALU, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("raw_stall_ctl", {4'h0, ctl1}, 8'hC);
      chk("raw_stall_busy", busy_mask, 8'h08);
      tick();
    end
    settle(); chk("raw_issue_ctl", {4'h0, ctl1}, 8'h00); chk("raw_issue_busy", busy_mask, 8'h00);
    tick();
    idle();
    settle(); chk("raw_after_busy", busy_mask, 8'h10);
    tick(); tick(); tick();
`else
    // Load-use with forwarding: exactly one stall cycle
    id_set(1'b1, OP_LD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
    tick();
    id_set(1'b1, OP_ALU, 3'd0, 1'b0, 3'd2, 1'b1, 3'd7, 1'b0);
    settle(); chk("ldu_stall_ctl", {4'h0, ctl1}, 8'hC);
    tick();
    settle(); chk("ldu_issue_ctl", {4'h0, ctl1}, 8'h00);
    tick();
    id_set(1'b1, OP_ALU, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
    tick();
    id_set(1'b1, OP_ALU, 3'd0, 1'b0, 3'd2, 1'b1, 3'd7, 1'b0);
    settle(); chk("alu_fwd_ctl", {4'h0, ctl1}, 8'h00);
    tick();
    idle();
    tick(); tick(); tick();
`endif
    settle(); chk("pre_br_busy", busy_mask, 8'h00);

    // Taken branch while decode hazards on r1: flush wins, nothing issues
    id_set(1'b1, OP_LD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1);
    tick();
    id_set(1'b1, OP_ALU, 3'd1, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1);
    br(1'b1, 1'b1);
    settle();
    chk("br_ctl", {4'h0, ctl1}, 8'h6);
    chk("br_ctl2", {4'h0, ctl2}, 8'h6);
    tick();
    idle();
    settle();
    chk("br_next_ctl", {4'h0, ctl1}, 8'h0);
    chk("br_next_busy", busy_mask, 8'h02);
    chk("br2_flush2_ctl", {4'h0, ctl2}, 8'h6);
    tick();
    settle(); chk("br2_end_ctl", {4'h0, ctl2}, 8'h0);
    tick(); tick();

    // Halt with r5 pending at count 2: two DRAIN cycles, then HALTED held
    id_set(1'b1, OP_ALU, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
    tick();
    idle();
    tick();
    id_set(1'b1, OP_HALT, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    settle(); chk("halt_issue_ctl", {4'h0, ctl1}, 8'h0); chk("halt_issue_busy", busy_mask, 8'h20);
    tick();
    idle();
    br(1'b1, 1'b1);
    settle(); chk("drain1_ctl", {4'h0, ctl1}, 8'hC); chk("drain1_busy", busy_mask, 8'h20);
    tick();
    settle(); chk("drain2_ctl", {4'h0, ctl1}, 8'hC); chk("drain2_busy", busy_mask, 8'h00);
    tick();
    br(1'b0, 1'b0);
    settle(); chk("halted_ctl", {4'h0, ctl1}, 8'hD);
    tick();
    settle(); chk("halted_hold_ctl", {4'h0, ctl1}, 8'hD);

    rst = 1'b1;
    settle(); chk("rst_halted_ctl", {4'h0, ctl1}, 8'h0);
    tick();
    rst = 1'b0;

    // Halt killed by a same-cycle taken branch
    id_set(1'b1, OP_ALU, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
    tick();
    idle();
    tick();
    id_set(1'b1, OP_HALT, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    br(1'b1, 1'b1);
    settle(); chk("halt_kill_ctl", {4'h0, ctl1}, 8'h6);
    tick();
    idle();
    settle(); chk("halt_kill_next", {4'h0, ctl1}, 8'h0);
    tick();
    settle(); chk("halt_kill_later", {4'h0, ctl1}, 8'h0);
    tick(); tick();

    // Reset in the middle of DRAIN takes effect without a clock edge
    id_set(1'b1, OP_ALU, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
    tick();
    id_set(1'b1, OP_HALT, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    idle();
    settle(); chk("mid_drain_ctl", {4'h0, ctl1}, 8'hC); chk("mid_drain_busy", busy_mask, 8'h20);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {4'h0, ctl1}, 8'h0);
    chk("mid_rst_busy", busy_mask, 8'h00);
    tick();
    rst = 1'b0;
    settle(); chk("post_rst_ctl", {4'h0, ctl1}, 8'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
